// File: rtl/sobel_tx_packer_pkg.sv
// Shared defaults, TX FSM state encoding and the pixel-to-bit helper for the
// Sobel edge-map UART packer.
package sobel_tx_packer_pkg;
  localparam int         IMG_W_DEF      = 320;
  localparam int         IMG_H_DEF      = 240;
  localparam int         FIFO_DEPTH_DEF = 16;
  localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } tx_state_e;

  // Thresholded input: any non-zero value is an edge.
  function automatic logic pix_bit(input logic [7:0] p);
    return p != 8'd0;
  endfunction
endpackage

// File: rtl/sobel_tx_packer_if.sv
// Pixel stream in, UART byte handshake out, plus frame/overflow status.
interface sobel_tx_packer_if;
  import sobel_tx_packer_pkg::*;
  logic [7:0] pixel_in;
  logic       pixel_in_valid;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       frame_done;
  logic       overflow;

  modport slave  (input  pixel_in, pixel_in_valid, tx_busy,
                  output tx_data, tx_start, frame_done, overflow);
  modport master (output pixel_in, pixel_in_valid, tx_busy,
                  input  tx_data, tx_start, frame_done, overflow);
endinterface

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO; a pop frees a slot for a push in the same cycle,
// so a full FIFO still accepts a push when it is also being drained.
module sync_byte_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [7:0]    i_data,
  input  logic          i_pop,
  output logic [7:0]    o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_count;
  logic          w_pop, w_push;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end
endmodule

// File: rtl/sobel_tx_packer.sv
// Packs 1-bit edge pixels MSB-first into bytes, prefixes each frame with a
// sync byte, buffers them and feeds a UART transmitter one byte at a time.
module sobel_tx_packer
  import sobel_tx_packer_pkg::*;
#(
  parameter int         IMG_W      = IMG_W_DEF,
  parameter int         IMG_H      = IMG_H_DEF,
  parameter int         FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  sobel_tx_packer_if.slave  bus
);
  localparam int             NPIX = IMG_W * IMG_H;
  localparam int             CW   = $clog2(NPIX);
  localparam int             FAW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0]  LAST = CW'(NPIX - 1);

  logic [CW-1:0] r_cnt;
  logic [6:0]    r_shift;
  logic          r_frame_done, r_overflow;
  logic [7:0]    r_tx_data;
  tx_state_e     r_state, w_next;

  logic          w_bit, w_push_sync, w_push_byte, w_push, w_drop;
  logic [7:0]    w_push_data, w_head;
  logic          w_full, w_empty, w_pop, w_start, w_load;
  logic [FAW:0]  w_count;

  assign w_bit       = pix_bit(bus.pixel_in);
  assign w_push_sync = bus.pixel_in_valid && (r_cnt == '0);
  assign w_push_byte = bus.pixel_in_valid && (r_cnt[2:0] == 3'd7);
  assign w_push      = w_push_sync || w_push_byte;
  assign w_push_data = w_push_sync ? SYNC_BYTE : {r_shift, w_bit};
  assign w_drop      = w_push && w_full && !w_pop;

  // Groups of 8 are frame-aligned, so the shift register never needs clearing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_shift      <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_frame_done <= bus.pixel_in_valid && (r_cnt == LAST);
      r_overflow   <= r_overflow || w_drop;
      if (bus.pixel_in_valid) begin
        r_shift <= {r_shift[5:0], w_bit};
        r_cnt   <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
      end
    end
  end

  sync_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (w_count != '0 && !bus.tx_busy) w_next = ST_LOAD;
      ST_LOAD:      w_next = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (bus.tx_busy) w_next = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!bus.tx_busy) w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_start = (r_state == ST_LOAD);
    w_pop   = w_start && !w_empty;
    w_load  = (r_state == ST_IDLE) && (w_next == ST_LOAD);
  end

  // Head is captured on entry to LOAD so tx_data is valid alongside tx_start
  // and held until the next byte is loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_tx_data <= '0;
    else if (w_load) r_tx_data <= w_head;
  end

  assign bus.tx_data    = r_tx_data;
  assign bus.tx_start   = w_start;
  assign bus.frame_done = r_frame_done;
  assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_sobel_tx_packer.sv
// Directed bench for sobel_tx_packer on a reduced 32x8 frame with a
// countdown UART busy model and a byte/timing monitor.
module tb_sobel_tx_packer;
  localparam int W = 32, H = 8, NPIX = W * H;

  logic clk = 1'b0;
  logic rst = 1'b0;
  sobel_tx_packer_if bus();

  sobel_tx_packer #(.IMG_W(W), .IMG_H(H), .FIFO_DEPTH(16), .SYNC_BYTE(8'hA5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // UART model: busy for busy_len cycles after each tx_start
  int   busy_len  = 10;
  logic hold_busy = 1'b0;
  int   busy_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst)               busy_cnt <= 0;
    else if (bus.tx_start) busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign bus.tx_busy = hold_busy || (busy_cnt != 0);

  logic [7:0] rx_q[$];
  logic [7:0] held;
  bit   in_tx, seen_busy;
  int   stab_err = 0, fd_cnt = 0, fd_cyc = -1, last_start_cyc = -1;

  always @(negedge clk) begin
    if (rst) begin
      in_tx = 1'b0; seen_busy = 1'b0;
    end else begin
      if (bus.frame_done) begin fd_cnt++; fd_cyc = cyc; end
      if (bus.tx_start) begin
        rx_q.push_back(bus.tx_data);
        last_start_cyc = cyc; held = bus.tx_data;
        in_tx = 1'b1; seen_busy = 1'b0;
      end else if (in_tx) begin
        if (bus.tx_data !== held) stab_err++;
        if (bus.tx_busy) seen_busy = 1'b1;
        else if (seen_busy) in_tx = 1'b0;
      end
    end
  end

  function automatic logic [7:0] pat(input int kind, input int i);
    case (kind)
      0:       return 8'd255;
      1:       return (i % 3 == 0) ? 8'd255 : 8'd0;
      2:       return (((i * 7) % 5) < 2) ? 8'd255 : 8'd0;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] model_byte(input int kind, input int g);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[7-k] = (pat(kind, 8*g + k) != 8'd0);
    return b;
  endfunction

  task automatic drive_pix(input logic [7:0] p);
    bus.pixel_in = p; bus.pixel_in_valid = 1'b1;
    @(negedge clk);
    bus.pixel_in_valid = 1'b0;
  endtask

  task automatic send_seq(input int kind, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      drive_pix(pat(kind, i));
      if (gaps) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.pixel_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rx_q.delete(); stab_err = 0; fd_cnt = 0; fd_cyc = -1; last_start_cyc = -1;
    rst = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget, input string tag);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin @(negedge clk); k++; end
    checks++;
    if (rx_q.size() < n) begin
      errors++; $display("FAIL %s timeout: got %0d bytes, need %0d", tag, rx_q.size(), n);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset tx_data: got %h want 00", bus.tx_data); end
    checks++; if (bus.tx_start !== 1'b0) begin errors++; $display("FAIL reset tx_start: got %b want 0", bus.tx_start); end
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset frame_done: got %b want 0", bus.frame_done); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset overflow: got %b want 0", bus.overflow); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL reset idle_tx: got %0d bytes want 0", rx_q.size()); end
  endtask

  task automatic test_basic();
    logic [7:0] px [8] = '{8'd255, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255};
    do_reset(); busy_len = 10;
    for (int i = 0; i < 8; i++) drive_pix(px[i]);
    wait_bytes(2, 200, "basic");
    repeat (30) @(negedge clk);
    checks++; if (rx_q.size() != 2) begin errors++; $display("FAIL basic count: got %0d want 2", rx_q.size()); end
    checks++; if (rx_q.size() < 1 || rx_q[0] !== 8'hA5) begin errors++; $display("FAIL basic sync: got %h want a5", rx_q.size() > 0 ? rx_q[0] : 8'hxx); end
    checks++; if (rx_q.size() < 2 || rx_q[1] !== 8'hA1) begin errors++; $display("FAIL basic byte: got %h want a1", rx_q.size() > 1 ? rx_q[1] : 8'hxx); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL basic stable: got %0d changes want 0", stab_err); end
  endtask

  task automatic test_latency();
    logic [7:0] px [8] = '{8'd0, 8'd255, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd255};
    int c;
    do_reset(); busy_len = 10;
    drive_pix(px[0]);
    wait_bytes(1, 100, "latency_sync");
    repeat (20) @(negedge clk);
    for (int i = 1; i < 7; i++) drive_pix(px[i]);
    c = cyc;
    drive_pix(px[7]);
    wait_bytes(2, 100, "latency");
    repeat (20) @(negedge clk);
    checks++; if (last_start_cyc != c + 2) begin errors++; $display("FAIL latency start: got cycle %0d want %0d", last_start_cyc, c + 2); end
    checks++; if (rx_q.size() < 2 || rx_q[1] !== 8'h65) begin errors++; $display("FAIL latency byte: got %h want 65", rx_q.size() > 1 ? rx_q[1] : 8'hxx); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL latency stable: got %0d changes want 0", stab_err); end
  endtask

  task automatic test_frame();
    int c = 0, bad = 0;
    do_reset(); busy_len = 2;
    for (int i = 0; i < NPIX; i++) begin
      if (i == NPIX - 1) c = cyc;
      drive_pix(8'd255);
    end
    repeat (10) @(negedge clk);
    drive_pix(8'd0);
    wait_bytes(NPIX/8 + 2, 2000, "frame");
    repeat (30) @(negedge clk);
    for (int k = 1; k <= NPIX/8 && k < rx_q.size(); k++) if (rx_q[k] !== 8'hFF) bad++;
    checks++; if (rx_q.size() != NPIX/8 + 2) begin errors++; $display("FAIL frame count: got %0d want %0d", rx_q.size(), NPIX/8 + 2); end
    checks++; if (rx_q.size() < 1 || rx_q[0] !== 8'hA5) begin errors++; $display("FAIL frame sync: got %h want a5", rx_q.size() > 0 ? rx_q[0] : 8'hxx); end
    checks++; if (bad != 0) begin errors++; $display("FAIL frame data: got %0d non-ff bytes want 0", bad); end
    checks++; if (rx_q.size() < NPIX/8 + 2 || rx_q[NPIX/8 + 1] !== 8'hA5) begin errors++; $display("FAIL frame wrap_sync: next frame byte not a5 (size %0d)", rx_q.size()); end
    checks++; if (fd_cnt != 1) begin errors++; $display("FAIL frame_done count: got %0d want 1", fd_cnt); end
    checks++; if (fd_cyc != c + 1) begin errors++; $display("FAIL frame_done cycle: got %0d want %0d", fd_cyc, c + 1); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL frame overflow: got %b want 0", bus.overflow); end
  endtask

  task automatic test_overflow();
    int bad = 0;
    logic [7:0] exp_b;
    hold_busy = 1'b1;
    do_reset(); busy_len = 2;
    send_seq(1, 200, 1'b0);
    repeat (3) @(negedge clk);
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL overflow set: got %b want 1", bus.overflow); end
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL overflow held: got %0d bytes while busy want 0", rx_q.size()); end
    hold_busy = 1'b0;
    wait_bytes(16, 500, "overflow_drain");
    repeat (40) @(negedge clk);
    for (int k = 0; k < 16 && k < rx_q.size(); k++) begin
      exp_b = (k == 0) ? 8'hA5 : model_byte(1, k - 1);
      if (rx_q[k] !== exp_b) bad++;
    end
    checks++; if (rx_q.size() != 16) begin errors++; $display("FAIL overflow count: got %0d want 16", rx_q.size()); end
    checks++; if (bad != 0) begin errors++; $display("FAIL overflow data: got %0d wrong bytes want 0", bad); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL overflow sticky: got %b want 1", bus.overflow); end
  endtask

  task automatic test_reset_mid();
    do_reset(); busy_len = 60;
    send_seq(2, 40, 1'b0);
    @(negedge clk);
    checks++; if (bus.tx_data !== 8'hA5) begin errors++; $display("FAIL midrst pre tx_data: got %h want a5", bus.tx_data); end
    rst = 1'b1;
    #1;
    checks++; if (bus.tx_data !== 8'h00 || bus.tx_start !== 1'b0 || bus.frame_done !== 1'b0 || bus.overflow !== 1'b0)
      begin errors++; $display("FAIL midrst outputs: got data=%h start=%b fd=%b ovf=%b want all 0", bus.tx_data, bus.tx_start, bus.frame_done, bus.overflow); end
    repeat (2) @(negedge clk);
    rx_q.delete();
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL midrst fifo_empty: got %0d bytes want 0", rx_q.size()); end
    drive_pix(8'd0);
    wait_bytes(1, 100, "midrst_sync");
    repeat (80) @(negedge clk);
    checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin errors++; $display("FAIL midrst resync: got %0d bytes first %h want 1 byte a5", rx_q.size(), rx_q.size() > 0 ? rx_q[0] : 8'hxx); end
  endtask

  task automatic test_gaps();
    logic [7:0] ref_q[$];
    int bad = 0;
    do_reset(); busy_len = 3;
    send_seq(2, 64, 1'b0);
    wait_bytes(9, 500, "gapfree");
    repeat (20) @(negedge clk);
    ref_q = rx_q;
    do_reset();
    send_seq(2, 64, 1'b1);
    wait_bytes(9, 500, "gaps");
    repeat (20) @(negedge clk);
    for (int k = 0; k < 9 && k < ref_q.size(); k++)
      if (ref_q[k] !== ((k == 0) ? 8'hA5 : model_byte(2, k - 1))) bad++;
    checks++; if (bad != 0 || ref_q.size() != 9) begin errors++; $display("FAIL gapfree stream: %0d wrong of %0d bytes", bad, ref_q.size()); end
    checks++; if (rx_q != ref_q) begin errors++; $display("FAIL gaps stream: got %0d bytes differing from %0d gap-free bytes", rx_q.size(), ref_q.size()); end
  endtask

  initial begin
    bus.pixel_in = 8'd0;
    bus.pixel_in_valid = 1'b0;
    test_reset();
    test_basic();
    test_latency();
    test_frame();
    test_overflow();
    test_reset_mid();
    test_gaps();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sobel_tx_packer.md
SOBEL_TX_PACKER -- requirements
Module: sobel_tx_packer

Interface
REQ-001 Parameter IMG_W, default 320: pixels per line.
REQ-002 Parameter IMG_H, default 240: lines per frame; IMG_W*IMG_H SHALL be a multiple of 8.
REQ-003 Parameter FIFO_DEPTH, default 16: byte FIFO entries, power of two.
REQ-004 Parameter SYNC_BYTE, default 8'hA5: frame header byte.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 pixel_in  in  8  thresholded Sobel pixel, 0 or 255.
REQ-008 pixel_in_valid  in  1  pixel_in qualifier, one pixel per asserted cycle.
REQ-009 tx_data  out  8  byte to UART transmitter.
REQ-010 tx_start  out  1  one-cycle transmit request.
REQ-011 tx_busy  in  1  UART transmitter busy.
REQ-012 frame_done  out  1  one-cycle pulse, last pixel of frame accepted.
REQ-013 overflow  out  1  sticky, a FIFO push was dropped.

Function
REQ-014 Pixel bit SHALL be 1 when pixel_in != 0, else 0.
REQ-015 Bits SHALL pack MSB-first: first pixel of each group into bit 7, eighth into bit 0.
REQ-016 Pixel counter SHALL run 0..IMG_W*IMG_H-1, increment per valid pixel, wrap to 0 after last pixel.
REQ-017 On valid pixel with counter 0, SYNC_BYTE SHALL be pushed to FIFO that cycle.
REQ-018 On every 8th valid pixel (counter[2:0]==7), completed byte SHALL be pushed; push visible in FIFO count next cycle.
REQ-019 SYNC and data pushes never coincide (counter 0 vs counter[2:0]==7); at most one push per cycle.
REQ-020 frame_done SHALL pulse one cycle after the valid pixel with counter IMG_W*IMG_H-1.
REQ-021 Push while FIFO full: byte dropped, FIFO unchanged, overflow set and held until reset.
REQ-022 Simultaneous push and pop with FIFO full: pop first, push accepted, no overflow.
REQ-023 TX FSM states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
REQ-024 IDLE -> LOAD when FIFO non-empty and tx_busy low; LOAD pops head into tx_data and asserts tx_start that cycle.
REQ-025 LOAD -> WAIT_BUSY unconditionally; WAIT_BUSY -> WAIT_DONE when tx_busy high.
REQ-026 WAIT_DONE -> IDLE when tx_busy low; tx_data SHALL stay stable from LOAD until IDLE.
REQ-027 Latency: 8th pixel at cycle N, FIFO previously empty, FSM idle, tx_busy low -> tx_start high at cycle N+2.
REQ-028 Bytes SHALL be transmitted in push order; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-029 pixel_in_valid low cycles SHALL not alter packer or counter state.

Reset
REQ-030 rst SHALL asynchronously clear pixel counter, shift register, FIFO pointers/count, FSM to IDLE.
REQ-031 Reset values: tx_data 0, tx_start 0, frame_done 0, overflow 0.
REQ-032 rst mid-frame or mid-transmission SHALL discard all buffered bytes; next valid pixel after release is counter 0 (SYNC pushed).

Structure
REQ-033 Shared package SHALL hold IMG_W/IMG_H defaults, SYNC_BYTE default and TX FSM state enum.
REQ-034 FIFO SHALL be sub-module sync_byte_fifo (push, pop, full, empty, count); packer and FSM stay in top.

Verification
REQ-035 8 valid pixels 255,0,255,0,0,0,0,255 from reset, tx_busy model 10-cycle -> bytes A5 then A1 transmitted.
REQ-036 Full 320x240 frame all 255 -> 1 A5 plus 9600 FF bytes, frame_done exactly one pulse after pixel 76799.
REQ-037 tx_busy held high, 200 continuous pixels -> FIFO fills at 16, overflow=1 stays set, first 16 bytes (A5 first) transmitted intact after release.
REQ-038 Pixel 8 at cycle N, idle, tx_busy low -> tx_start at N+2, tx_data stable until tx_busy falls.
REQ-039 rst asserted during WAIT_DONE with 5 bytes queued -> all outputs 0, FIFO empty; next pixel produces A5 first.
REQ-040 Gaps in pixel_in_valid (every other cycle) -> byte stream identical to gap-free run.
